// File: rtl/div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative 32-bit restoring radix-2 divider for DIV/DIVU in EX.
//            One quotient bit per cycle. Divide-by-zero has a short path
//            that returns 0. An operation in progress can be flushed with
//            annul_i.
// Ports    : clk          - system clock (rising edge)
//            rst          - synchronous active-high reset
//            signed_div_i - 1 = signed DIV, 0 = unsigned DIVU (sampled w/ start)
//            opdata1_i    - dividend (sampled with start)
//            opdata2_i    - divisor  (sampled with start)
//            start_i      - request, held until the result is consumed
//            annul_i      - abort a running operation
//            result_o     - {remainder, quotient}, registered
//            ready_o      - result valid, registered
// Revision : 1.0 - initial release
// ============================================================================
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   localparam logic [1:0] S_FREE    = 2'd0;
   localparam logic [1:0] S_BY_ZERO = 2'd1;
   localparam logic [1:0] S_ON      = 2'd2;
   localparam logic [1:0] S_END     = 2'd3;

   localparam logic [5:0] C_LAST_CNT = 6'd32;

   logic [1:0]  r_state;
   logic [5:0]  r_cnt;
   logic [64:0] r_dividend;
   logic [31:0] r_divisor;
   logic        r_signed;
   logic        r_neg1;
   logic        r_neg2;

   logic [1:0]  w_state_nxt;
   logic [5:0]  w_cnt_nxt;
   logic [64:0] w_dividend_nxt;
   logic [31:0] w_divisor_nxt;
   logic        w_signed_nxt;
   logic        w_neg1_nxt;
   logic        w_neg2_nxt;
   logic [63:0] w_result_nxt;
   logic        w_ready_nxt;

   logic [31:0] w_abs_op1;
   logic [31:0] w_abs_op2;
   logic [32:0] w_diff;
   logic [31:0] w_quot;
   logic [31:0] w_rem;

   // Magnitudes of the operands; 0x80000000 negates to itself, which is the
   // correct unsigned magnitude, so no special case is needed.
   assign w_abs_op1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
   assign w_abs_op2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

   // Trial subtraction of the divisor from the partial remainder; bit 32 set
   // means the subtraction went negative and the partial remainder is kept.
   assign w_diff = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};

   // Sign fix-up of the final magnitudes (truncating division semantics).
   assign w_quot = (r_signed && (r_neg1 ^ r_neg2)) ? (~r_dividend[31:0] + 32'd1)
                                                   : r_dividend[31:0];
   assign w_rem  = (r_signed && r_neg1) ? (~r_dividend[64:33] + 32'd1)
                                        : r_dividend[64:33];

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FREE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FREE: begin
            if (start_i && !annul_i) begin
               w_state_nxt = (opdata2_i == 32'd0) ? S_BY_ZERO : S_ON;
            end
         end
         S_BY_ZERO: begin
            w_state_nxt = S_END;
         end
         S_ON: begin
            if (annul_i) begin
               w_state_nxt = S_FREE;
            end else if (r_cnt == C_LAST_CNT) begin
               w_state_nxt = S_END;
            end
         end
         S_END: begin
            if (!start_i) begin
               w_state_nxt = S_FREE;
            end
         end
         default: begin
            w_state_nxt = S_FREE;
         end
      endcase
   end

   // Datapath and output next values
   always_comb begin
      w_cnt_nxt      = r_cnt;
      w_dividend_nxt = r_dividend;
      w_divisor_nxt  = r_divisor;
      w_signed_nxt   = r_signed;
      w_neg1_nxt     = r_neg1;
      w_neg2_nxt     = r_neg2;
      w_result_nxt   = result_o;
      w_ready_nxt    = ready_o;
      case (r_state)
         S_FREE: begin
            w_ready_nxt  = 1'b0;
            w_result_nxt = 64'd0;
            if (start_i && !annul_i) begin
               w_signed_nxt = signed_div_i;
               w_neg1_nxt   = signed_div_i & opdata1_i[31];
               w_neg2_nxt   = signed_div_i & opdata2_i[31];
               if (opdata2_i != 32'd0) begin
                  w_cnt_nxt      = 6'd0;
                  w_dividend_nxt = {32'd0, w_abs_op1, 1'b0};
                  w_divisor_nxt  = w_abs_op2;
               end
            end
         end
         S_BY_ZERO: begin
            w_dividend_nxt = 65'd0;
            w_result_nxt   = 64'd0;
            w_ready_nxt    = 1'b1;
         end
         S_ON: begin
            if (annul_i) begin
               w_cnt_nxt    = 6'd0;
               w_result_nxt = 64'd0;
               w_ready_nxt  = 1'b0;
            end else if (r_cnt != C_LAST_CNT) begin
               if (w_diff[32]) begin
                  w_dividend_nxt = {r_dividend[63:0], 1'b0};
               end else begin
                  w_dividend_nxt = {w_diff[31:0], r_dividend[31:0], 1'b1};
               end
               w_cnt_nxt = r_cnt + 6'd1;
            end else begin
               w_result_nxt = {w_rem, w_quot};
               w_ready_nxt  = 1'b1;
            end
         end
         S_END: begin
            if (!start_i) begin
               w_result_nxt = 64'd0;
               w_ready_nxt  = 1'b0;
            end
         end
         default: begin
            w_result_nxt = 64'd0;
            w_ready_nxt  = 1'b0;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= 6'd0;
         r_dividend <= 65'd0;
         r_divisor  <= 32'd0;
         r_signed   <= 1'b0;
         r_neg1     <= 1'b0;
         r_neg2     <= 1'b0;
         result_o   <= 64'd0;
         ready_o    <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_dividend <= w_dividend_nxt;
         r_divisor  <= w_divisor_nxt;
         r_signed   <= w_signed_nxt;
         r_neg1     <= w_neg1_nxt;
         r_neg2     <= w_neg2_nxt;
         result_o   <= w_result_nxt;
         ready_o    <= w_ready_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Self-checking bench for div_unit: directed vector table,
//            annul/reset corner sequences and random operations checked
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        start;
   logic        annul;
   logic [63:0] result;
   logic        ready;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          hold;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: truncating division done in 64-bit arithmetic, so the
   // 0x80000000 / -1 case cannot overflow. Divide by zero yields 0.
   function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         sa = longint'(signed'(a));
         sb = longint'(signed'(b));
      end else begin
         sa = {32'd0, a};
         sb = {32'd0, b};
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // One full handshake: start, wait for ready (bounded), check latency and
   // result, hold start for 'hold' extra cycles, then release and check clear.
   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int hold, input string tag);
      int lat;
      int explat;
      explat = (b == 32'd0) ? 1 : 33;
      @(negedge clk);
      signed_div = s;
      op1        = a;
      op2        = b;
      start      = 1'b1;
      @(posedge clk);
      #1;
      check({tag, " ready low after start edge"}, {63'd0, ready}, 64'd0);
      // Operands must be ignored after the sampling edge.
      signed_div = 1'($urandom);
      op1        = $urandom;
      op2        = $urandom;
      lat = 0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (ready) begin
            lat = k;
            break;
         end
      end
      check({tag, " latency"}, 64'(lat), 64'(explat));
      check({tag, " result"}, result, exp);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         check({tag, " ready held"}, {63'd0, ready}, 64'd1);
         check({tag, " result held"}, result, exp);
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check({tag, " ready dropped"}, {63'd0, ready}, 64'd0);
      check({tag, " result cleared"}, result, 64'd0);
   endtask

   // Watches ready for n cycles; it must stay low throughout.
   task automatic expect_quiet(input int n, input string tag);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         if (ready) seen = 1'b1;
      end
      check({tag, " ready stays low"}, {63'd0, seen}, 64'd0);
   endtask

   initial begin
      logic        s;
      logic [31:0] a;
      logic [31:0] b;

      rst        = 1'b1;
      start      = 1'b0;
      annul      = 1'b0;
      signed_div = 1'b0;
      op1        = 32'd0;
      op2        = 32'd0;

      vecs[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 0};
      vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 1};
      vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 0};
      vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 0};
      vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 5};
      vecs[5] = '{1'b0, 32'd5,          32'd0,          64'h00000000_00000000, 0};
      vecs[6] = '{1'b1, 32'hFFFFFFF0,   32'd0,          64'h00000000_00000000, 2};
      vecs[7] = '{1'b0, 32'd1,          32'hFFFFFFFF,   64'h00000001_00000000, 0};
      vecs[8] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 0};

      repeat (3) @(posedge clk);
      #1;
      check("reset ready", {63'd0, ready}, 64'd0);
      check("reset result", result, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold,
                $sformatf("vec%0d", i));
      end

      // annul in FREE suppresses the start
      @(negedge clk);
      op1 = 32'd20; op2 = 32'd5; signed_div = 1'b0; start = 1'b1; annul = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("annul in FREE ready", {63'd0, ready}, 64'd0);
      @(negedge clk);
      start = 1'b0; annul = 1'b0;
      run_op(1'b0, 32'd20, 32'd5, 64'h00000000_00000004, 0, "after free annul");

      // annul at cnt==10
      @(negedge clk);
      op1 = 32'd50; op2 = 32'd3; signed_div = 1'b0; start = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      annul = 1'b1; start = 1'b0;
      @(posedge clk);
      #1;
      check("annul ready", {63'd0, ready}, 64'd0);
      check("annul result", result, 64'd0);
      @(negedge clk);
      annul = 1'b0;
      expect_quiet(40, "annul");
      run_op(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 0, "after annul");

      // reset at cnt==20
      @(negedge clk);
      op1 = 32'hFFFFFF00; op2 = 32'd7; signed_div = 1'b1; start = 1'b1;
      @(posedge clk);
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst = 1'b1; start = 1'b0;
      @(posedge clk);
      #1;
      check("mid reset ready", {63'd0, ready}, 64'd0);
      check("mid reset result", result, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      expect_quiet(40, "mid reset");
      run_op(1'b1, 32'hFFFFFF9C, 32'd7, ref_div(1'b1, 32'hFFFFFF9C, 32'd7), 0, "after reset");

      // random operations against the reference model
      for (int i = 0; i < 24; i++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 4))
            0:       b = $urandom;
            1:       b = 32'($urandom_range(0, 15));
            2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 14));
            3:       b = 32'($urandom_range(1, 1000));
            default: begin b = $urandom >> $urandom_range(0, 31); a = a >> $urandom_range(0, 31); end
         endcase
         run_op(s, a, b, ref_div(s, a, b), i % 3, $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
